// File: rtl/obi_mem_responder_pkg.sv
// obi_mem_responder_pkg: shared constants and range check for the OBI memory responder
package obi_mem_responder_pkg;
  localparam int WordBytes = 4;
  function automatic logic in_range(input logic [63:0] off, input int unsigned num_words);
    return off < 64'(num_words) * 64'(WordBytes);
  endfunction
endpackage

// File: rtl/obi_mem_rsp_fifo.sv
// obi_mem_rsp_fifo: synchronous response FIFO with full/empty flags and occupancy count
module obi_mem_rsp_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = Depth > 1 ? $clog2(Depth) : 1;
  logic [Width-1:0] mem [Depth];
  logic [PW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == CW'(Depth);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wptr] <= wdata;
      if (do_push) wptr <= wptr == PW'(Depth - 1) ? '0 : wptr + 1'b1;
      if (do_pop) rptr <= rptr == PW'(Depth - 1) ? '0 : rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI subordinate with byte-enabled word memory and buffered responses; OBI_MEM_RESP_ERR_EN enables range errors
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int                 AddrWidth = 32,
  parameter int                 DataWidth = 32,
  parameter int                 IdWidth   = 1,
  parameter int                 NumWords  = 16,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int                 RspDepth  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o
);
  localparam int IW = $clog2(NumWords);
  localparam int CW = $clog2(RspDepth + 1);
  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } rsp_entry_t;
  logic [DataWidth-1:0] mem [NumWords];
  logic [AddrWidth-1:0] off;
  logic [IW-1:0] idx;
  logic hs, err, full, empty, unused;
  logic [CW-1:0] count;
  rsp_entry_t push_e, head;
  assign gnt_o = ~full;
  assign hs = req_i & gnt_o;
  assign off = addr_i - BaseAddr;
  assign idx = off[IW+1:2];
`ifdef OBI_MEM_RESP_ERR_EN
  assign err = ~in_range(64'(off), NumWords);
`else
  assign err = 1'b0;
`endif
  assign unused = ^{off, count};
  assign push_e = '{rdata: (we_i | err) ? '0 : mem[idx], rid: aid_i, err: err};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < NumWords; w++) mem[w] <= '0;
    end else if (hs & we_i & ~err) begin
      for (int b = 0; b < DataWidth / 8; b++)
        if (be_i[b]) mem[idx][b*8+:8] <= wdata_i[b*8+:8];
    end
  end
  obi_mem_rsp_fifo #(.Width($bits(rsp_entry_t)), .Depth(RspDepth)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (hs),
    .pop   (rvalid_o & rready_i),
    .wdata (push_e),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign rvalid_o = ~empty;
  assign rdata_o = head.rdata;
  assign rid_o = head.rid;
  assign err_o = head.err;
endmodule
